// File: rtl/dma_mon_pkg.sv
// Shared definitions for the DMA-vs-protected-region monitors: FSM encoding,
// default reset-handler address and the region upper-bound helper.
package dma_mon_pkg;

  localparam logic STATE_RUN  = 1'b0;
  localparam logic STATE_KILL = 1'b1;

  typedef enum logic {
    RUN  = STATE_RUN,
    KILL = STATE_KILL
  } dma_state_e;

  localparam logic [15:0] DEFAULT_RESET_HANDLER = 16'h0000;

  // One extra bit so a window ending exactly at the top of the address space
  // does not wrap to zero. Supports address widths up to 32 bits.
  function automatic logic [32:0] region_end(input logic [31:0] base,
                                             input logic [31:0] size);
    return {1'b0, base} + {1'b0, size};
  endfunction

endpackage

// File: rtl/dma_region_match.sv
// Single protected window comparator: flags a DMA beat that lands inside the
// window and is of a kind (any access, or writes only) the window forbids.
module dma_region_match
  import dma_mon_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE     = '0,
  parameter logic [ADDR_W-1:0] SIZE     = '0,
  parameter bit              WRITE_ONLY = 1'b0
) (
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_en,
  input  logic              dma_we,
  output logic              viol
);

  localparam logic [32:0] REGION_END = region_end(32'(BASE), 32'(SIZE));
  localparam bit          ENABLED    = (SIZE != '0);

  logic hit;

  always_comb begin
    hit  = dma_en && ENABLED && (dma_addr >= BASE) && (33'(dma_addr) < REGION_END);
    viol = hit && (!WRITE_ONLY || dma_we);
  end

endmodule

// File: rtl/dma_x_regions.sv
// Multi-region DMA monitor: raises a sticky core reset on any forbidden DMA
// beat and keeps a first-fault log plus a saturating violation count.
module dma_x_regions
  import dma_mon_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 2,
  parameter int IDX_W       = 3,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hA000, 16'h6000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {16'h1000, 16'h0800},
  parameter logic [NUM_REGIONS-1:0]        WRITE_ONLY  = 2'b00,
  parameter logic [ADDR_W-1:0] RESET_HANDLER = ADDR_W'(DEFAULT_RESET_HANDLER),
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_en,
  input  logic              dma_we,
  output logic              reset,
  output logic              viol_valid,
  output logic [IDX_W-1:0]  viol_region,
  output logic [ADDR_W-1:0] viol_addr,
  output logic [CNT_W-1:0]  viol_count
);

  logic [NUM_REGIONS-1:0] viol;
  logic                   invalid;
  logic [IDX_W-1:0]       first_idx;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    dma_region_match #(
      .ADDR_W    (ADDR_W),
      .BASE      (REGION_BASE[g*ADDR_W +: ADDR_W]),
      .SIZE      (REGION_SIZE[g*ADDR_W +: ADDR_W]),
      .WRITE_ONLY(WRITE_ONLY[g])
    ) u_match (
      .dma_addr(dma_addr),
      .dma_en  (dma_en),
      .dma_we  (dma_we),
      .viol    (viol[g])
    );
  end

  // Scan from the top down so the lowest violating index wins on overlap.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (viol[i]) first_idx = IDX_W'(i);
    end
    invalid = |viol;
  end

  dma_state_e        state_q, state_d;
  logic              reset_q, reset_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  region_q, region_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    region_d = region_q;
    addr_d   = addr_q;
    count_d  = count_q;
    case (state_q)
      RUN: begin
        if (invalid) begin
          state_d = KILL;
          if (!valid_q) begin
            valid_d  = 1'b1;
            region_d = first_idx;
            addr_d   = dma_addr;
          end
          if (count_q != '1) count_d = count_q + CNT_W'(1);
        end
      end
      KILL: begin
        if ((pc == RESET_HANDLER) && !invalid) state_d = RUN;
      end
      default: state_d = KILL;
    endcase
    reset_d = (state_d == KILL);
  end

  // The log survives the FSM's own reset request; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= KILL;
      reset_q  <= 1'b1;
      valid_q  <= 1'b0;
      region_q <= '0;
      addr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      reset_q  <= reset_d;
      valid_q  <= valid_d;
      region_q <= region_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
    end
  end

  assign reset       = reset_q;
  assign viol_valid  = valid_q;
  assign viol_region = region_q;
  assign viol_addr   = addr_q;
  assign viol_count  = count_q;

endmodule

// File: tb/tb_dma_x_regions.sv
// Directed bench for dma_x_regions: default build, a write-only region 0 build
// and a build whose region 1 ends at the top of the address space.
module tb_dma_x_regions;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic        en_a, en_w, en_t;

  logic        reset_a, reset_w, reset_t;
  logic        valid_a, valid_w, valid_t;
  logic [2:0]  region_a, region_w, region_t;
  logic [15:0] addr_a, addr_w, addr_t;
  logic [7:0]  count_a, count_w, count_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dma_x_regions u_dut (
    .clk(clk), .rst(rst), .pc(pc), .dma_addr(dma_addr), .dma_en(en_a), .dma_we(dma_we),
    .reset(reset_a), .viol_valid(valid_a), .viol_region(region_a), .viol_addr(addr_a),
    .viol_count(count_a)
  );

  dma_x_regions #(.WRITE_ONLY(2'b01)) u_wo (
    .clk(clk), .rst(rst), .pc(pc), .dma_addr(dma_addr), .dma_en(en_w), .dma_we(dma_we),
    .reset(reset_w), .viol_valid(valid_w), .viol_region(region_w), .viol_addr(addr_w),
    .viol_count(count_w)
  );

  dma_x_regions #(.REGION_BASE({16'hF000, 16'h6000}), .REGION_SIZE({16'h1000, 16'h0800})) u_top (
    .clk(clk), .rst(rst), .pc(pc), .dma_addr(dma_addr), .dma_en(en_t), .dma_we(dma_we),
    .reset(reset_t), .viol_valid(valid_t), .viol_region(region_t), .viol_addr(addr_t),
    .viol_count(count_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 16'h1234; dma_addr = 16'h0000; dma_we = 1'b0;
    en_a = 1'b0; en_w = 1'b0; en_t = 1'b0;
    tick(); tick();
    checks++; if (reset_a !== 1'b1) begin errors++; $display("FAIL rst_reset_a: got %b exp 1", reset_a); end
    checks++; if (reset_w !== 1'b1) begin errors++; $display("FAIL rst_reset_w: got %b exp 1", reset_w); end
    checks++; if (reset_t !== 1'b1) begin errors++; $display("FAIL rst_reset_t: got %b exp 1", reset_t); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", valid_a); end
    checks++; if (count_a !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count_a); end
    checks++; if (addr_a !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h exp 0000", addr_a); end
    rst = 1'b0;
    tick();
    // pc is not the handler yet, so KILL must hold
    checks++; if (reset_a !== 1'b1) begin errors++; $display("FAIL hold_no_handler: got %b exp 1", reset_a); end
    pc = 16'h0000;
    tick();
    checks++; if (reset_a !== 1'b0) begin errors++; $display("FAIL release_a: got %b exp 0", reset_a); end
    checks++; if (reset_w !== 1'b0) begin errors++; $display("FAIL release_w: got %b exp 0", reset_w); end
    checks++; if (reset_t !== 1'b0) begin errors++; $display("FAIL release_t: got %b exp 0", reset_t); end
    checks++; if (valid_a !== 1'b0 || count_a !== 8'd0) begin errors++; $display("FAIL release_log: got valid %b count %0d exp 0 0", valid_a, count_a); end
  endtask

  task automatic test_kill_region1();
    en_a = 1'b1; dma_addr = 16'hA7FF;
    tick();
    exp_q.push_back(16'hA7FF);
    checks++; if (reset_a !== 1'b1) begin errors++; $display("FAIL kill_reset: got %b exp 1", reset_a); end
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL kill_valid: got %b exp 1", valid_a); end
    checks++; if (region_a !== 3'd1) begin errors++; $display("FAIL kill_region: got %0d exp 1", region_a); end
    checks++; if (addr_a !== 16'hA7FF) begin errors++; $display("FAIL kill_addr: got %h exp A7FF", addr_a); end
    checks++; if (count_a !== 8'd1) begin errors++; $display("FAIL kill_count: got %0d exp 1", count_a); end
    en_a = 1'b0;
    tick();
    checks++; if (reset_a !== 1'b0) begin errors++; $display("FAIL kill_recover: got %b exp 0", reset_a); end
  endtask

  task automatic test_boundaries();
    logic [15:0] addrs [8];
    logic        kills [8];
    addrs = '{16'h9FFF, 16'hB000, 16'hA000, 16'hAFFF, 16'h5FFF, 16'h6800, 16'h6000, 16'h67FF};
    kills = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1; dma_addr = addrs[i];
      tick();
      checks++; if (reset_a !== kills[i]) begin errors++; $display("FAIL bound_%h: got %b exp %b", addrs[i], reset_a, kills[i]); end
      en_a = 1'b0;
      tick();
      checks++; if (reset_a !== 1'b0) begin errors++; $display("FAIL bound_recover_%h: got %b exp 0", addrs[i], reset_a); end
    end
    checks++; if (count_a !== 8'd5) begin errors++; $display("FAIL bound_count: got %0d exp 5", count_a); end
    checks++; if (addr_a !== 16'hA7FF || region_a !== 3'd1) begin errors++; $display("FAIL bound_first_fault: got %h/%0d exp A7FF/1", addr_a, region_a); end
  endtask

  task automatic test_write_only();
    en_w = 1'b0; dma_we = 1'b1; dma_addr = 16'h6010;
    tick();
    checks++; if (reset_w !== 1'b0) begin errors++; $display("FAIL wo_we_without_en: got %b exp 0", reset_w); end
    en_w = 1'b1; dma_we = 1'b0;
    tick();
    checks++; if (reset_w !== 1'b0) begin errors++; $display("FAIL wo_read: got %b exp 0", reset_w); end
    dma_we = 1'b1;
    tick();
    checks++; if (reset_w !== 1'b1) begin errors++; $display("FAIL wo_write: got %b exp 1", reset_w); end
    checks++; if (region_w !== 3'd0 || addr_w !== 16'h6010) begin errors++; $display("FAIL wo_log: got %0d/%h exp 0/6010", region_w, addr_w); end
    checks++; if (count_w !== 8'd1) begin errors++; $display("FAIL wo_count: got %0d exp 1", count_w); end
    en_w = 1'b0; dma_we = 1'b0;
    tick();
    checks++; if (reset_w !== 1'b0) begin errors++; $display("FAIL wo_recover: got %b exp 0", reset_w); end
  endtask

  task automatic test_top_region();
    en_t = 1'b1; dma_addr = 16'hEFFF;
    tick();
    checks++; if (reset_t !== 1'b0) begin errors++; $display("FAIL top_below: got %b exp 0", reset_t); end
    dma_addr = 16'hFFFF;
    tick();
    checks++; if (reset_t !== 1'b1) begin errors++; $display("FAIL top_ffff: got %b exp 1", reset_t); end
    checks++; if (region_t !== 3'd1 || addr_t !== 16'hFFFF) begin errors++; $display("FAIL top_log: got %0d/%h exp 1/FFFF", region_t, addr_t); end
    en_t = 1'b0;
    tick();
  endtask

  task automatic test_kill_hold();
    en_a = 1'b1; dma_addr = 16'hA100; pc = 16'h0000;
    tick();
    checks++; if (reset_a !== 1'b1) begin errors++; $display("FAIL hold_enter: got %b exp 1", reset_a); end
    tick();
    checks++; if (reset_a !== 1'b1) begin errors++; $display("FAIL hold_simult: got %b exp 1", reset_a); end
    checks++; if (count_a !== 8'd6) begin errors++; $display("FAIL hold_count: got %0d exp 6", count_a); end
    en_a = 1'b0;
    tick();
    checks++; if (reset_a !== 1'b0) begin errors++; $display("FAIL hold_release: got %b exp 0", reset_a); end
    en_a = 1'b1;
    tick();
    en_a = 1'b0; pc = 16'h1234;
    tick();
    checks++; if (reset_a !== 1'b1) begin errors++; $display("FAIL hold_pc_off: got %b exp 1", reset_a); end
    pc = 16'h0000;
    tick();
    checks++; if (reset_a !== 1'b0 || count_a !== 8'd7) begin errors++; $display("FAIL hold_pc_on: got %b/%0d exp 0/7", reset_a, count_a); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      en_a = 1'b1; dma_addr = 16'hA000 + 16'(i);
      tick();
      en_a = 1'b0;
      tick();
    end
    checks++; if (count_a !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d exp 255", count_a); end
    checks++; if (addr_a !== exp_q[0]) begin errors++; $display("FAIL sat_first_addr: got %h exp %h", addr_a, exp_q[0]); end
    checks++; if (region_a !== 3'd1 || valid_a !== 1'b1) begin errors++; $display("FAIL sat_first_region: got %0d/%b exp 1/1", region_a, valid_a); end
    checks++; if (reset_a !== 1'b0) begin errors++; $display("FAIL sat_run: got %b exp 0", reset_a); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (reset_a !== 1'b1) begin errors++; $display("FAIL async_reset: got %b exp 1", reset_a); end
    checks++; if (valid_a !== 1'b0 || count_a !== 8'd0) begin errors++; $display("FAIL async_log: got %b/%0d exp 0/0", valid_a, count_a); end
    checks++; if (addr_a !== 16'h0000 || region_a !== 3'd0) begin errors++; $display("FAIL async_capture: got %h/%0d exp 0000/0", addr_a, region_a); end
    checks++; if (valid_w !== 1'b0 || valid_t !== 1'b0) begin errors++; $display("FAIL async_others: got %b/%b exp 0/0", valid_w, valid_t); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_kill_region1();
    test_boundaries();
    test_write_only();
    test_top_region();
    test_kill_hold();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_x_regions.md
Name: dma_X_regions

Overview:
- Parametrised successor to the single-region DMA-vs-secure-data monitor.
- Watches the DMA bus against NUM_REGIONS protected address windows, each independently configurable to block all DMA accesses or only DMA writes.
- Drives a sticky hardware-reset request that is released only when the CPU is fetching at the reset handler with no DMA violation present.
- Adds violation logging (region index, address, saturating count) for post-reset forensics. Sits beside the other hw-mod monitors and feeds the core reset OR-tree.

Parameters:
- ADDR_W, 16, width of pc and dma_addr.
- NUM_REGIONS, 2, number of protected windows (1..8).
- IDX_W, 3, width of the region index output; must satisfy 2**IDX_W >= NUM_REGIONS.
- REGION_BASE, {16'hA000,16'h6000}, packed NUM_REGIONS*ADDR_W base addresses; region i occupies slice i.
- REGION_SIZE, {16'h1000,16'h0800}, packed NUM_REGIONS*ADDR_W sizes; size 0 disables the region.
- WRITE_ONLY, 2'b00, per-region mode bit. 0 = any DMA access violates; 1 = only DMA writes violate.
- RESET_HANDLER, 16'h0000, pc value at which KILL may be released.
- CNT_W, 8, width of the violation counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pc  input  ADDR_W  current CPU program counter
- dma_addr  input  ADDR_W  DMA address
- dma_en  input  1  DMA access strobe
- dma_we  input  1  DMA write qualifier, valid when dma_en=1
- reset  output  1  reset request to core, 1 = hold in reset
- viol_valid  output  1  a violation has been logged since rst
- viol_region  output  IDX_W  region index of the first logged violation
- viol_addr  output  ADDR_W  dma_addr of the first logged violation
- viol_count  output  CNT_W  number of RUN->KILL transitions, saturating

Behaviour:
- Region match (combinational):
  - hit_i = dma_en && size_i!=0 && dma_addr >= base_i && dma_addr < base_i+size_i.
  - The upper-bound sum is computed in ADDR_W+1 bits, so a region ending exactly at 2**ADDR_W (e.g. base F000, size 1000) is legal and matches FFFF.
  - viol_i = hit_i && (!WRITE_ONLY[i] || dma_we).
  - invalid = OR of all viol_i.
  - Overlapping regions: the lowest index with viol_i=1 is reported.
- FSM states RUN=0, KILL=1.
- On rst assertion (async): state=KILL, reset=1, viol_valid=0, viol_region=0, viol_addr=0, viol_count=0.
- Transitions, evaluated at posedge clk:
  - RUN with invalid -> KILL. reset goes to 1 on that same edge, i.e. one cycle after the offending beat is sampled.
  - KILL with pc==RESET_HANDLER and !invalid -> RUN. reset goes to 0 on the same edge.
  - KILL with pc==RESET_HANDLER and invalid (simultaneous) -> stays KILL, reset stays 1.
  - Otherwise state holds; reset = (state==KILL).
- Logging occurs on each RUN->KILL edge:
  - If viol_valid=0: capture viol_region (priority index) and viol_addr, then set viol_valid=1.
  - Later violations do not overwrite the capture; first-fault semantics hold until rst.
  - viol_count increments on each RUN->KILL edge and saturates at all-ones (255 must not wrap to 0).
  - Violations seen while already in KILL do not count.
- Log registers are cleared only by rst, never by the FSM's own reset request, so software can read them after the core restarts.
- rst mid-operation takes effect immediately: outputs return to reset values asynchronously, with no dependence on clk.
- dma_we is ignored when dma_en=0.

Decomposition:
- Shared package dma_mon_pkg:
  - state localparams RUN/KILL;
  - default RESET_HANDLER;
  - helper function for the region upper bound (ADDR_W+1 add).
- Sub-module dma_region_match:
  - one instance per region via generate;
  - inputs: dma_addr, dma_en, dma_we, plus base/size/write_only parameters;
  - output: viol_i.
- Top level holds the priority encoder, FSM, log registers and counter.

Test Plan:
- rst pulse, then pc=0000 with dma_en=0 for 1 clk -> reset 1 then 0; viol_valid=0, viol_count=0.
- In RUN, dma_en=1, dma_addr=A7FF -> next edge reset=1; viol_region=1, viol_addr=A7FF, viol_count=1.
- WRITE_ONLY[0]=1 build: dma_addr=6010 with dma_we=0 -> no kill; same address with dma_we=1 -> kill, viol_region=0.
- Boundaries on region 1: dma_addr=9FFF and B000 -> no kill; A000 and AFFF -> kill. Extra build with region at F000/1000: FFFF -> kill.
- In KILL, pc=0000 while dma_addr=A100 and dma_en=1 -> stays KILL, reset=1. Next cycle dma_en=0 -> RUN, reset=0.
- 300 kill/recover cycles -> viol_count=255, and viol_addr still holds the first address. Assert rst between clock edges -> all outputs reset immediately.
